mux_2to1_core: RTL and testbench

- Parameterised 2:1 data selector with an optional one-cycle output register.
- Passes bus `a` when select `s`=0 and bus `b` when `s`=1.
- General-purpose datapath steering element; the WIDTH=1 instance is the gate-level 2:1 mux (operands A, B, select S, output Y).
- Adds a capture enable and output-valid flag so it can sit inside pipelined datapaths.

---
 rtl/mux_2to1_core.sv | 68 ++++++
 tb/tb_mux_2to1_core.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mux_2to1_core.sv
// mux_2to1_core: parameterised 2:1 data selector with optional output register.
// REG_OUT=1 registers y/y_valid (1-cycle latency); REG_OUT=0 is purely combinational.
// Optional macro MUX_PARITY_EN adds y_par, the XOR reduction of y.
module mux_2to1_core #(
  parameter int              WIDTH     = 1,
  parameter bit              REG_OUT   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
`ifdef MUX_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [WIDTH-1:0] sel;

  // Plain 2-input select; X on s is deliberately left unresolved.
  always_comb begin
    sel = s ? b : a;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] y_q;
      logic             y_valid_q;

      // Capture on enabled edges; y holds when en=0 while valid drops.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y_q       <= RESET_VAL;
          y_valid_q <= 1'b0;
        end else begin
          if (en) begin
            y_q <= sel;
          end
          y_valid_q <= en;
        end
      end

      assign y       = y_q;
      assign y_valid = y_valid_q;
    end else begin : g_comb
      // No state in this mode, so the clock is intentionally left unused.
      logic unused_clk;
      assign unused_clk = clk;

      // Reset forces the reset value and clears valid without a clock.
      always_comb begin
        y       = rst ? RESET_VAL : sel;
        y_valid = en & ~rst;
      end
    end
  endgenerate

`ifdef MUX_PARITY_EN
  // Derived from y so it inherits y's timing and reset value in both modes.
  assign y_par = ^y;
`endif

endmodule

// File: tb/tb_mux_2to1_core.sv
// Directed bench for mux_2to1_core: a 1-bit combinational instance and an
// 8-bit registered instance (RESET_VAL=8'h5A) share one clock.
module tb_mux_2to1_core;

  logic       clk = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // 1-bit combinational instance
  logic       rst1, a1, b1, s1, en1;
  logic       y1, v1;
  // 8-bit registered instance
  logic       rst8, s8, en8;
  logic [7:0] a8, b8, y8;
  logic       v8;
`ifdef MUX_PARITY_EN
  logic       p1, p8;
`endif

  always #5 clk = ~clk;

  mux_2to1_core #(.WIDTH(1), .REG_OUT(1'b0), .RESET_VAL(1'b0)) u_comb (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .s(s1), .en(en1),
    .y(y1), .y_valid(v1)
`ifdef MUX_PARITY_EN
    , .y_par(p1)
`endif
  );

  mux_2to1_core #(.WIDTH(8), .REG_OUT(1'b1), .RESET_VAL(8'h5A)) u_reg (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .s(s8), .en(en8),
    .y(y8), .y_valid(v8)
`ifdef MUX_PARITY_EN
    , .y_par(p8)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] tt_exp;
    logic [2:0] vec;
    tt_exp = 8'b1101_1000;   // y for {a,b,s} = 0..7

    rst1 = 1'b1; a1 = 1'b1; b1 = 1'b0; s1 = 1'b0; en1 = 1'b1;
    rst8 = 1'b1; a8 = 8'h00; b8 = 8'h00; s8 = 1'b0; en8 = 1'b1;
    #1;
    // Combinational reset
    chk("comb_rst_y", {7'd0, y1}, 8'h00);
    chk("comb_rst_valid", {7'd0, v1}, 8'h00);
    chk("reg_rst_y", y8, 8'h5A);
    chk("reg_rst_valid", {7'd0, v8}, 8'h00);
`ifdef MUX_PARITY_EN
    chk("reg_rst_par", {7'd0, p8}, 8'h00);
`endif
    rst1 = 1'b0;
    #1;
    chk("comb_release_y", {7'd0, y1}, 8'h01);
    chk("comb_release_valid", {7'd0, v1}, 8'h01);

    // Truth table, each vector held 10 ns
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      a1 = vec[2]; b1 = vec[1]; s1 = vec[0];
      #5;
      chk($sformatf("truth_%0d", i), {7'd0, y1}, {7'd0, tt_exp[i]});
`ifdef MUX_PARITY_EN
      chk($sformatf("truth_par_%0d", i), {7'd0, p1}, {7'd0, tt_exp[i]});
`endif
      #5;
    end
    en1 = 1'b0;
    #1;
    chk("comb_en0_valid", {7'd0, v1}, 8'h00);

    // Registered latency
    @(negedge clk);
    rst8 = 1'b0; a8 = 8'h3C; b8 = 8'hA5; s8 = 1'b1; en8 = 1'b1;
    #1;
    chk("lat_pre_edge", y8, 8'h5A);
    edge_settle();
    chk("lat_y_b", y8, 8'hA5);
    chk("lat_valid", {7'd0, v8}, 8'h01);
    #2;
    s8 = 1'b0;
    #1;
    chk("lat_midcycle_hold", y8, 8'hA5);
    edge_settle();
    chk("lat_y_a", y8, 8'h3C);

`ifdef MUX_PARITY_EN
    // Parity follows the registered y
    #2;
    b8 = 8'h07; s8 = 1'b1;
    edge_settle();
    chk("par_y07", y8, 8'h07);
    chk("par_07", {7'd0, p8}, 8'h01);
    #2;
    a8 = 8'h03; s8 = 1'b0;
    edge_settle();
    chk("par_y03", y8, 8'h03);
    chk("par_03", {7'd0, p8}, 8'h00);
`endif

    // Enable hold
    #2;
    b8 = 8'hA5; s8 = 1'b1; en8 = 1'b1;
    edge_settle();
    chk("hold_capture", y8, 8'hA5);
    #2;
    en8 = 1'b0; s8 = 1'b0; a8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      edge_settle();
      chk($sformatf("hold_y_%0d", k), y8, 8'hA5);
      chk($sformatf("hold_valid_%0d", k), {7'd0, v8}, 8'h00);
    end

    // Async reset between edges, overriding en
    #2;
    en8 = 1'b1; s8 = 1'b1; b8 = 8'hA5;
    rst8 = 1'b1;
    #1;
    chk("arst_y", y8, 8'h5A);
    chk("arst_valid", {7'd0, v8}, 8'h00);
    edge_settle();
    chk("arst_override_y", y8, 8'h5A);
    chk("arst_override_valid", {7'd0, v8}, 8'h00);
    @(negedge clk);
    rst8 = 1'b0; en8 = 1'b1; s8 = 1'b0; a8 = 8'h11;
    #1;
    chk("arst_release_pre", y8, 8'h5A);
    edge_settle();
    chk("arst_release_y", y8, 8'h11);
    chk("arst_release_valid", {7'd0, v8}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
